// File: rtl/paddle_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : paddle_ctrl                                                     |
// | Purpose  : Per-frame paddle controller: erase / move / draw into the frame |
// |            buffer. Optional macro PADDLE_BTN_SYNC_EN adds button sync and  |
// |            per-frame latching of the button pair.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module paddle_ctrl #(
    parameter int PADDLE_W = 16,
    parameter int PADDLE_H = 2,
    parameter int Y_ROW    = 109,
    parameter int X_INIT   = 72,
    parameter int X_MAX    = 144,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       left,
    input  logic       right,
    output logic [7:0] x_paddle,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] color_out,
    output logic       writeEn,
    output logic       done
);

    localparam int c_COL_W = (PADDLE_W > 1) ? $clog2(PADDLE_W) : 1;
    localparam int c_ROW_W = (PADDLE_H > 1) ? $clog2(PADDLE_H) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(PADDLE_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(PADDLE_H - 1);
    localparam logic [7:0]         c_X_INIT   = 8'(X_INIT);
    localparam logic [7:0]         c_X_MAX    = 8'(X_MAX);
    localparam logic [7:0]         c_STEP     = 8'(STEP);
    localparam logic [8:0]         c_X_MAX_W  = 9'(X_MAX);
    localparam logic [6:0]         c_Y_ROW    = 7'(Y_ROW);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERASE = 3'd1,
        S_MOVE  = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_COL_W-1:0]   col_q, col_d;
    logic [c_ROW_W-1:0]   row_q, row_d;
    logic [7:0]           x_q, x_d;

    logic                 w_left;
    logic                 w_right;
    logic                 w_last;
    logic [8:0]           w_sum;

`ifdef PADDLE_BTN_SYNC_EN
    // Two-flop synchronizer, then the pair is frozen when the frame is accepted
    logic [1:0] btn_meta_q;
    logic [1:0] btn_sync_q;
    logic [1:0] btn_lat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q <= 2'b00;
            btn_sync_q <= 2'b00;
            btn_lat_q  <= 2'b00;
        end else begin
            btn_meta_q <= {left, right};
            btn_sync_q <= btn_meta_q;
            if (state_q == S_IDLE && go) begin
                btn_lat_q <= btn_sync_q;
            end
        end
    end

    assign w_left  = btn_lat_q[1];
    assign w_right = btn_lat_q[0];
`else
    assign w_left  = left;
    assign w_right = right;
`endif

    assign w_last = (col_q == c_COL_LAST) && (row_q == c_ROW_LAST);
    assign w_sum  = {1'b0, x_q} + {1'b0, c_STEP};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            x_q     <= c_X_INIT;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            x_q     <= x_d;
        end
    end

    // Counters sit at zero outside ERASE/DRAW, so both plot phases start at (0,0)
    always_comb begin
        state_d = state_q;
        col_d   = '0;
        row_d   = '0;
        x_d     = x_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_ERASE;
                end
            end
            S_ERASE, S_DRAW: begin
                if (w_last) begin
                    state_d = (state_q == S_ERASE) ? S_MOVE : S_DONE;
                end else if (col_q == c_COL_LAST) begin
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                    row_d = row_q;
                end
            end
            S_MOVE: begin
                state_d = S_DRAW;
                if (w_left && !w_right) begin
                    // Compare first so the left clamp never wraps below zero
                    x_d = (x_q < c_STEP) ? 8'd0 : (x_q - c_STEP);
                end else if (w_right && !w_left) begin
                    x_d = (w_sum > c_X_MAX_W) ? c_X_MAX : w_sum[7:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        writeEn   = 1'b0;
        color_out = 3'b000;
        done      = 1'b0;
        case (state_q)
            S_ERASE: writeEn = 1'b1;
            S_DRAW: begin
                writeEn   = 1'b1;
                color_out = 3'b111;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign x_paddle = x_q;
    assign x_out    = x_q + {{(8 - c_COL_W){1'b0}}, col_q};
    assign y_out    = c_Y_ROW + {{(7 - c_ROW_W){1'b0}}, row_q};

endmodule

`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_paddle_ctrl                                                  |
// | Purpose  : Directed self-checking bench for paddle_ctrl (a second instance |
// |            starts at x=3 to reach the odd left-limit case).                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_paddle_ctrl;

    localparam int W  = 16;
    localparam int N  = 32;
    localparam int NF = 2 * N + 2;
    localparam int YR = 109;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic       left;
    logic       right;

    logic [7:0] x_paddle, x_out;
    logic [6:0] y_out;
    logic [2:0] color_out;
    logic       writeEn, done;

    logic [7:0] xp_b, xo_b;
    logic [6:0] yo_b;
    logic [2:0] co_b;
    logic       we_b, dn_b;

    int checks   = 0;
    int failures = 0;

    logic [27:0] cap_v   [1:NF];
    logic [27:0] cap_b   [1:NF];
    logic [7:0]  cap_xmax;
    logic [7:0]  xa;

    always #5 clk = ~clk;

    paddle_ctrl u_dut (
        .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
        .x_paddle(x_paddle), .x_out(x_out), .y_out(y_out),
        .color_out(color_out), .writeEn(writeEn), .done(done)
    );

    paddle_ctrl #(.X_INIT(3)) u_dut_odd (
        .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
        .x_paddle(xp_b), .x_out(xo_b), .y_out(yo_b),
        .color_out(co_b), .writeEn(we_b), .done(dn_b)
    );

    // Expected {writeEn, colour, x_out, y_out, done, x_paddle} at frame sample i
    function automatic logic [27:0] exp_vec(input int i, input logic [7:0] xo,
                                            input logic [7:0] xn);
        logic       we = 1'b0;
        logic [2:0] c  = 3'd0;
        logic       d  = 1'b0;
        logic [6:0] y  = 7'(YR);
        logic [7:0] x;
        logic [7:0] xp;
        int         p;
        if (i <= N) begin
            p = i - 1; we = 1'b1; xp = xo; x = xo + 8'(p % W); y = 7'(YR + p / W);
        end else if (i == N + 1) begin
            xp = xo; x = xo;
        end else if (i <= 2 * N + 1) begin
            p = i - N - 2; we = 1'b1; c = 3'd7; xp = xn;
            x = xn + 8'(p % W); y = 7'(YR + p / W);
        end else begin
            xp = xn; x = xn; d = 1'b1;
        end
        return {we, c, x, y, d, xp};
    endfunction

    task automatic set_buttons(input logic l, input logic r);
        left  = l;
        right = r;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Stimulus/capture only: one accepted go, NF samples, ends back in IDLE
    task automatic run_frame(input int pulse_at, input int right_at);
        go = 1'b1;
        @(posedge clk);
        #1;
        cap_xmax = 8'd0;
        for (int i = 1; i <= NF; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            cap_v[i] = {writeEn, color_out, x_out, y_out, done, x_paddle};
            cap_b[i] = {we_b, co_b, xo_b, yo_b, dn_b, xp_b};
            if (writeEn && x_out > cap_xmax) cap_xmax = x_out;
            go = (i == pulse_at);
            if (i == right_at) right = 1'b1;
        end
        go = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        go = 1'b0; left = 1'b0; right = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({writeEn, done, color_out, x_paddle, x_out, y_out} !==
                {1'b0, 1'b0, 3'd0, 8'd72, 8'd72, 7'd109}) begin
                failures++;
                $display("FAIL reset_idle[%0d] got we=%b done=%b col=%0d xp=%0d x=%0d y=%0d want 0 0 0 72 72 109",
                         i, writeEn, done, color_out, x_paddle, x_out, y_out);
            end
        end
        checks++;
        if (xp_b !== 8'd3) begin
            failures++;
            $display("FAIL reset_odd_xp got %0d want 3", xp_b);
        end
        xa = 8'd72;
    endtask

    task automatic test_single_frame();
        run_frame(0, 0);
        for (int i = 1; i <= NF; i++) begin
            checks++;
            if (cap_v[i] !== exp_vec(i, 8'd72, 8'd72)) begin
                failures++;
                $display("FAIL single_frame[%0d] got %h want %h", i, cap_v[i],
                         exp_vec(i, 8'd72, 8'd72));
            end
        end
    endtask

    task automatic test_right_clamp();
        logic [7:0] xn;
        set_buttons(1'b0, 1'b1);
        for (int f = 0; f < 40; f++) begin
            xn = (xa >= 8'd142) ? 8'd144 : xa + 8'd2;
            run_frame(0, 0);
            checks++;
            if (cap_v[NF][7:0] !== xn) begin
                failures++;
                $display("FAIL right_step[%0d] got xp=%0d want %0d", f, cap_v[NF][7:0], xn);
            end
            checks++;
            if (cap_xmax !== ((xn > xa) ? xn : xa) + 8'd15) begin
                failures++;
                $display("FAIL right_xmax[%0d] got %0d want %0d", f, cap_xmax,
                         ((xn > xa) ? xn : xa) + 8'd15);
            end
            if (f == 39) begin
                for (int i = 1; i <= NF; i++) begin
                    checks++;
                    if (cap_v[i] !== exp_vec(i, 8'd144, 8'd144)) begin
                        failures++;
                        $display("FAIL right_final[%0d] got %h want %h", i, cap_v[i],
                                 exp_vec(i, 8'd144, 8'd144));
                    end
                end
            end
            xa = xn;
        end
        set_buttons(1'b0, 1'b0);
    endtask

    task automatic test_left_clamp();
        logic [1:0] btn   [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
        logic [7:0] exp_a [5] = '{8'd70, 8'd68, 8'd66, 8'd66, 8'd66};
        logic [7:0] exp_b [5] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        logic [1:0] b;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int f = 0; f < 5; f++) begin
            b = btn[f];
            set_buttons(b[1], b[0]);
            run_frame(0, 0);
            checks++;
            if (cap_b[NF][7:0] !== exp_b[f]) begin
                failures++;
                $display("FAIL left_odd[%0d] got xp=%0d want %0d", f, cap_b[NF][7:0], exp_b[f]);
            end
            checks++;
            if (cap_v[NF][7:0] !== exp_a[f]) begin
                failures++;
                $display("FAIL left_main[%0d] got xp=%0d want %0d", f, cap_v[NF][7:0], exp_a[f]);
            end
        end
        for (int i = 1; i <= NF; i++) begin
            checks++;
            if (cap_b[i] !== exp_vec(i, 8'd0, 8'd0)) begin
                failures++;
                $display("FAIL left_zero_frame[%0d] got %h want %h", i, cap_b[i],
                         exp_vec(i, 8'd0, 8'd0));
            end
        end
        xa = 8'd66;
    endtask

    task automatic test_reset_mid_draw();
        set_buttons(1'b0, 1'b1);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        for (int i = 2; i <= N + 12; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if ({writeEn, color_out, x_out, x_paddle} !== {1'b1, 3'd7, 8'd78, 8'd68}) begin
            failures++;
            $display("FAIL mid_draw_px10 got we=%b col=%0d x=%0d xp=%0d want 1 7 78 68",
                     writeEn, color_out, x_out, x_paddle);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if ({writeEn, done, color_out, x_paddle, x_out, y_out} !==
            {1'b0, 1'b0, 3'd0, 8'd72, 8'd72, 7'd109}) begin
            failures++;
            $display("FAIL mid_draw_reset got we=%b done=%b col=%0d xp=%0d x=%0d y=%0d want 0 0 0 72 72 109",
                     writeEn, done, color_out, x_paddle, x_out, y_out);
        end
        set_buttons(1'b0, 1'b0);
        run_frame(0, 0);
        for (int i = 1; i <= NF; i++) begin
            checks++;
            if (cap_v[i] !== exp_vec(i, 8'd72, 8'd72)) begin
                failures++;
                $display("FAIL after_reset_frame[%0d] got %h want %h", i, cap_v[i],
                         exp_vec(i, 8'd72, 8'd72));
            end
        end
        xa = 8'd72;
    endtask

    task automatic test_back_to_back();
        int done_seen;
        int done_at [3];
        logic [7:0] x1;
        logic [7:0] x2;

        run_frame(5, 0);
        for (int i = 1; i <= NF; i++) begin
            checks++;
            if (cap_v[i] !== exp_vec(i, 8'd72, 8'd72)) begin
                failures++;
                $display("FAIL go_pulse_frame[%0d] got %h want %h", i, cap_v[i],
                         exp_vec(i, 8'd72, 8'd72));
            end
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({writeEn, done} !== 2'b00) begin
                failures++;
                $display("FAIL no_extra_frame[%0d] got we=%b done=%b want 0 0", i, writeEn, done);
            end
            @(posedge clk);
            #1;
        end

`ifdef PADDLE_BTN_SYNC_EN
        x1 = 8'd72;
        x2 = 8'd74;
`else
        x1 = 8'd74;
        x2 = 8'd76;
`endif
        right = 1'b0;
        run_frame(0, 5);
        checks++;
        if (cap_v[NF][7:0] !== x1) begin
            failures++;
            $display("FAIL right_in_erase got xp=%0d want %0d", cap_v[NF][7:0], x1);
        end
        run_frame(0, 0);
        checks++;
        if (cap_v[NF][7:0] !== x2) begin
            failures++;
            $display("FAIL right_next_frame got xp=%0d want %0d", cap_v[NF][7:0], x2);
        end
        set_buttons(1'b0, 1'b0);

        done_seen = 0;
        go = 1'b1;
        for (int e = 1; e <= 300 && done_seen < 3; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_at[done_seen] = e;
                done_seen++;
            end
        end
        go = 1'b0;
        checks++;
        if (done_seen != 3) begin
            failures++;
            $display("FAIL go_held_count got %0d done pulses want 3", done_seen);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (done_at[k] != 66 + 67 * k) begin
                    failures++;
                    $display("FAIL go_held_done[%0d] got edge %0d want %0d", k, done_at[k], 66 + 67 * k);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        go = 1'b0; left = 1'b0; right = 1'b0; reset = 1'b1;
        test_reset();
        test_single_frame();
        test_right_clamp();
        test_left_clamp();
        test_reset_mid_draw();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/paddle_ctrl.md
# paddle_ctrl

Per-frame paddle controller. Owns the paddle's horizontal position, moves it from two push-button levels, and plots the paddle into the frame buffer with an erase/move/draw sequence. It sits directly upstream of the ball stage. It feeds `x_paddle` to the ball's bounce logic, and its pixel outputs go to the VGA write mux alongside the ball's.

## Interface
- `PADDLE_W`, 16: paddle width in pixels; 2..64.
- `PADDLE_H`, 2: paddle height in pixels; 1..4.
- `Y_ROW`, 109: top row of the paddle; matches the ball's bounce row.
- `X_INIT`, 72: `x_paddle` value after reset.
- `X_MAX`, 144: largest legal `x_paddle`; equals 160 − `PADDLE_W`.
- `STEP`, 2: pixels moved per frame.

- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `go`, in, 1: request one frame update; sampled only in IDLE.
- `left`, in, 1: button level, active-high.
- `right`, in, 1: button level, active-high.
- `x_paddle`, out, 8: current paddle left edge, registered.
- `x_out`, out, 8: plot x.
- `y_out`, out, 7: plot y.
- `color_out`, out, 3: plot colour.
- `writeEn`, out, 1: plot strobe, one pixel per cycle.
- `done`, out, 1: one-cycle pulse when the frame update completes.

## Operation
- The FSM has five states: IDLE, ERASE, MOVE, DRAW, DONE.
  - IDLE: go to ERASE if `go`=1, otherwise stay in IDLE.
  - ERASE: go to MOVE when the pixel counter reaches its last pixel.
  - MOVE: go to DRAW, always after one cycle.
  - DRAW: go to DONE when the pixel counter reaches its last pixel.
  - DONE: go to IDLE, always after one cycle.
- Pixel counter:
  - A column counter `col` runs 0..`PADDLE_W`−1. A row counter `row` runs 0..`PADDLE_H`−1.
  - `col` increments each cycle. `row` increments when `col` wraps.
  - Both counters clear to 0 on entry to ERASE and on entry to DRAW.
- Plot outputs:
  - `x_out` = `x_paddle` + `col`, in 8 bits.
  - `y_out` = `Y_ROW` + `row`, in 7 bits.
  - With legal parameters these never overflow, because `X_MAX` + `PADDLE_W` − 1 ≤ 159.
- `writeEn` is 1 only in ERASE and DRAW.
- `color_out` is 3'b111 in DRAW and 3'b000 otherwise.
- Move rule, evaluated in the MOVE cycle:
  - `left`=1 and `right`=0: `x_paddle` ← max(`x_paddle` − `STEP`, 0). Compute this without unsigned underflow; compare before subtracting.
  - `right`=1 and `left`=0: `x_paddle` ← min(`x_paddle` + `STEP`, `X_MAX`).
  - Both buttons or neither: no change.
- `x_paddle` changes only on the clock edge that ends MOVE.
  - ERASE uses the old position and DRAW uses the new one, so the erased pixels are exactly the previously drawn ones.
- `done` = 1 only in DONE.
- `go` outside IDLE is ignored. It is not queued.

## Timing
- Reset values:
  - State IDLE, `col`=`row`=0.
  - `x_paddle`=`X_INIT`.
  - `writeEn`=0, `color_out`=0, `done`=0.
  - `x_out`=`X_INIT`, `y_out`=`Y_ROW`.
- Let N = `PADDLE_W`·`PADDLE_H`.
- `go` accepted at edge k gives:
  - ERASE during cycles k+1..k+N.
  - MOVE at k+N+1.
  - DRAW during k+N+2..k+2N+1.
  - DONE (`done`=1) at k+2N+2.
  - IDLE at k+2N+3.
- Defaults (N=32): `done` is high 66 cycles after the accepting edge.
- `go` held high: a new frame starts every 2N+3 cycles, with one IDLE cycle between frames.
- Pixel order within ERASE and DRAW is row-major: (`col` 0, `row` 0) first, (`PADDLE_W`−1, `PADDLE_H`−1) last. One pixel per cycle, no gaps.
- Reset asserted in any state:
  - Next state is IDLE.
  - `writeEn` drops on the following cycle.
  - `x_paddle` returns to `X_INIT`.
  - A partially plotted paddle is left in the frame buffer; the next frame's ERASE does not remove it.
- Buttons at a limit: pressing `left` at `x_paddle`=1 with `STEP`=2 gives 0. Pressing `left` at 0 leaves 0.

## Configuration
- Macro: `PADDLE_BTN_SYNC_EN`.
- Defined:
  - `left` and `right` each pass through a two-flop synchronizer.
  - The synchronized pair is then latched on the edge that accepts `go`.
  - MOVE uses the latched pair, so button changes during a frame have no effect on that frame.
  - Button input must be stable at least 2 cycles before `go` is accepted.
- Undefined: MOVE uses the raw `left`/`right` levels present in the MOVE cycle. No added flops.

## Test plan
- Reset then idle:
  - Hold `reset` 2 cycles, then release.
  - Expect `x_paddle`=72, `writeEn`=0, `done`=0 for 10 cycles with `go`=0.
- Single frame, no buttons:
  - Pulse `go`.
  - Expect 32 writes of colour 0 covering x 72..87, y 109..110 in row-major order, one MOVE cycle with `writeEn`=0, then the same 32 pixels with colour 7.
  - Expect `done` pulse exactly 66 cycles after the `go` edge; `x_paddle` stays 72.
- Right held for 40 frames:
  - `x_paddle` steps 74, 76, … and clamps at 144.
  - Final DRAW covers x 144..159; never x ≥ 160.
- Left held from `x_paddle`=3:
  - Values are 1, then 0, then 0.
  - Never wraps to 254/255.
  - Both buttons held: no change.
- Reset mid-DRAW:
  - Assert `reset` at DRAW pixel 10.
  - Next cycle: `writeEn`=0, state IDLE, `x_paddle`=72.
  - A subsequent `go` produces a full 66-cycle frame.
- `go` during ERASE and held high:
  - Extra pulses produce no extra frames.
  - Continuous `go` yields `done` every 67 cycles.
  - With `PADDLE_BTN_SYNC_EN`, a `right` press starting during ERASE does not move the paddle that frame; it moves on the next frame.
